// File: rtl/xilinx_pcie_rx_engine.sv
// -----------------------------------------------------------------------------
// xilinx_pcie_rx_engine
//
// Receive-side TLP engine sitting between the PCIe core's 128-bit AXIS RX port
// and the application. Only 3DW-header TLPs are decoded:
//   - MRd  (fmt_type 7'h00): header fields are latched onto the req_* bus and a
//          one-cycle req_compl pulse asks the completer for a completion. The
//          RX port is stalled until compl_done.
//   - MWr  (fmt_type 7'h40): the first payload DW becomes a single wr_en pulse.
//          Any further payload beats are dropped.
//   - CplD (fmt_type 7'h4A): the payload is re-packed so that payload DW0 lands
//          in cpl_data[31:0], tagged with the TLP tag and delivered through a
//          1-deep valid/ready output register.
//   - everything else is dropped.
//
// Ports
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   m_axis_rx_*            AXIS RX beat from the core (tready driven here)
//   req_*                  MRd completion request towards the TX completer
//   compl_done             completer finished the requested completion
//   wr_en/wr_addr/wr_be/wr_data   single-DW register write strobe
//   cpl_data/cpl_dw_valid/cpl_tag/cpl_last/cpl_valid/cpl_ready
//                          re-aligned completion payload stream
// -----------------------------------------------------------------------------
module xilinx_pcie_rx_engine #(
    parameter int P_DATA_WIDTH = 128,
    parameter int P_KEEP_WIDTH = P_DATA_WIDTH / 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,

    input  logic [P_DATA_WIDTH-1:0] m_axis_rx_tdata,
    input  logic [P_KEEP_WIDTH-1:0] m_axis_rx_tkeep,
    input  logic                    m_axis_rx_tlast,
    input  logic                    m_axis_rx_tvalid,
    output logic                    m_axis_rx_tready,

    output logic                    req_compl,
    output logic                    req_compl_wd,
    output logic [2:0]              req_tc,
    output logic                    req_td,
    output logic                    req_ep,
    output logic [1:0]              req_attr,
    output logic [9:0]              req_len,
    output logic [15:0]             req_rid,
    output logic [7:0]              req_tag,
    output logic [7:0]              req_be,
    output logic [31:0]             req_addr,
    input  logic                    compl_done,

    output logic                    wr_en,
    output logic [31:0]             wr_addr,
    output logic [3:0]              wr_be,
    output logic [31:0]             wr_data,

    output logic [127:0]            cpl_data,
    output logic [3:0]              cpl_dw_valid,
    output logic [7:0]              cpl_tag,
    output logic                    cpl_last,
    output logic                    cpl_valid,
    input  logic                    cpl_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_DISCARD,
        S_STREAM,
        S_FLUSH
    } state_t;

    localparam logic [6:0] FT_MRD  = 7'h00;
    localparam logic [6:0] FT_MWR  = 7'h40;
    localparam logic [6:0] FT_CPLD = 7'h4A;

    state_t state_q, state_d;

    logic         req_compl_q, req_compl_d;
    logic         req_compl_wd_q, req_compl_wd_d;
    logic [2:0]   req_tc_q, req_tc_d;
    logic         req_td_q, req_td_d;
    logic         req_ep_q, req_ep_d;
    logic [1:0]   req_attr_q, req_attr_d;
    logic [9:0]   req_len_q, req_len_d;
    logic [15:0]  req_rid_q, req_rid_d;
    logic [7:0]   req_tag_q, req_tag_d;
    logic [7:0]   req_be_q, req_be_d;
    logic [31:0]  req_addr_q, req_addr_d;

    logic         wr_en_q, wr_en_d;
    logic [31:0]  wr_addr_q, wr_addr_d;
    logic [3:0]   wr_be_q, wr_be_d;
    logic [31:0]  wr_data_q, wr_data_d;

    logic [127:0] cpl_data_q, cpl_data_d;
    logic [3:0]   cpl_dw_valid_q, cpl_dw_valid_d;
    logic [7:0]   cpl_tag_q, cpl_tag_d;
    logic         cpl_last_q, cpl_last_d;
    logic         cpl_valid_q, cpl_valid_d;

    // Tag of the CplD being streamed. Kept apart from cpl_tag so that a new
    // CplD header accepted while the previous final word is still stalled
    // does not change the tag under that word.
    logic [7:0]   tag_hold_q, tag_hold_d;
    // Payload DW carried over to the next output word (the header beat and
    // every payload beat leave their top DW behind).
    logic [31:0]  scratch_q, scratch_d;
    // Payload DWs not yet emitted; 1024 needs the 11th bit.
    logic [10:0]  rem_q, rem_d;

    logic [31:0]  dw0, dw1, dw2, dw3;
    logic [6:0]   fmt_type;
    logic [10:0]  hdr_len;
    logic         out_free;
    logic         beat_acc;
    logic [3:0]   stream_mask;
    logic [10:0]  stream_rem;
    logic         unused_ok;

    assign dw0      = m_axis_rx_tdata[31:0];
    assign dw1      = m_axis_rx_tdata[63:32];
    assign dw2      = m_axis_rx_tdata[95:64];
    assign dw3      = m_axis_rx_tdata[127:96];
    assign fmt_type = dw0[30:24];
    assign hdr_len  = (dw0[9:0] == 10'd0) ? 11'd1024 : {1'b0, dw0[9:0]};

    // Byte enables are implied by the Length field; header reserved bits and
    // the low address bits are not needed.
    assign unused_ok = ^{m_axis_rx_tkeep, m_axis_rx_tdata};

    // The output register can take a new word when empty or draining now.
    assign out_free = !cpl_valid_q || cpl_ready;

    assign m_axis_rx_tready = (state_q == S_IDLE) || (state_q == S_DISCARD) ||
                              ((state_q == S_STREAM) && out_free);

    assign beat_acc = m_axis_rx_tvalid && m_axis_rx_tready;

    // Valid-DW mask and remaining count for a payload beat in STREAM.
    always_comb begin
        stream_mask = 4'hF;
        stream_rem  = 11'd0;
        if (rem_q >= 11'd4) begin
            stream_mask = 4'hF;
            stream_rem  = rem_q - 11'd4;
        end else begin
            case (rem_q[1:0])
                2'd1:    stream_mask = 4'h1;
                2'd2:    stream_mask = 4'h3;
                2'd3:    stream_mask = 4'h7;
                default: stream_mask = 4'h0;
            endcase
        end
    end

    always_comb begin
        state_d        = state_q;
        req_compl_d    = 1'b0;
        req_compl_wd_d = req_compl_wd_q;
        req_tc_d       = req_tc_q;
        req_td_d       = req_td_q;
        req_ep_d       = req_ep_q;
        req_attr_d     = req_attr_q;
        req_len_d      = req_len_q;
        req_rid_d      = req_rid_q;
        req_tag_d      = req_tag_q;
        req_be_d       = req_be_q;
        req_addr_d     = req_addr_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_be_d        = wr_be_q;
        wr_data_d      = wr_data_q;
        cpl_data_d     = cpl_data_q;
        cpl_dw_valid_d = cpl_dw_valid_q;
        cpl_tag_d      = cpl_tag_q;
        cpl_last_d     = cpl_last_q;
        cpl_valid_d    = cpl_valid_q && !cpl_ready;
        tag_hold_d     = tag_hold_q;
        scratch_d      = scratch_q;
        rem_d          = rem_q;

        case (state_q)
            S_IDLE: begin
                if (beat_acc) begin
                    case (fmt_type)
                        FT_MRD: begin
                            req_compl_d    = 1'b1;
                            req_compl_wd_d = 1'b1;
                            req_tc_d       = dw0[22:20];
                            req_td_d       = dw0[15];
                            req_ep_d       = dw0[14];
                            req_attr_d     = dw0[13:12];
                            req_len_d      = dw0[9:0];
                            req_rid_d      = dw1[31:16];
                            req_tag_d      = dw1[15:8];
                            req_be_d       = dw1[7:0];
                            req_addr_d     = {dw2[31:2], 2'b00};
                            state_d        = S_RD_WAIT;
                        end
                        FT_MWR: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = {dw2[31:2], 2'b00};
                            wr_be_d   = dw1[3:0];
                            wr_data_d = dw3;
                            state_d   = m_axis_rx_tlast ? S_IDLE : S_DISCARD;
                        end
                        FT_CPLD: begin
                            tag_hold_d = dw2[15:8];
                            scratch_d  = dw3;
                            rem_d      = hdr_len;
                            state_d    = m_axis_rx_tlast ? S_FLUSH : S_STREAM;
                        end
                        default: begin
                            state_d = m_axis_rx_tlast ? S_IDLE : S_DISCARD;
                        end
                    endcase
                end
            end

            S_RD_WAIT: begin
                if (compl_done) begin
                    state_d = S_IDLE;
                end
            end

            S_DISCARD: begin
                if (beat_acc && m_axis_rx_tlast) begin
                    state_d = S_IDLE;
                end
            end

            S_STREAM: begin
                if (beat_acc) begin
                    cpl_data_d     = {m_axis_rx_tdata[95:0], scratch_q};
                    scratch_d      = m_axis_rx_tdata[127:96];
                    cpl_dw_valid_d = stream_mask;
                    cpl_tag_d      = tag_hold_q;
                    cpl_valid_d    = 1'b1;
                    rem_d          = stream_rem;
                    cpl_last_d     = 1'b0;
                    if (m_axis_rx_tlast) begin
                        // More than four DWs outstanding means the DW parked
                        // in scratch still needs a word of its own.
                        if (rem_q > 11'd4) begin
                            state_d = S_FLUSH;
                        end else begin
                            cpl_last_d = 1'b1;
                            state_d    = S_IDLE;
                        end
                    end
                end
            end

            S_FLUSH: begin
                if (out_free) begin
                    cpl_data_d     = {96'd0, scratch_q};
                    cpl_dw_valid_d = 4'b0001;
                    cpl_tag_d      = tag_hold_q;
                    cpl_last_d     = 1'b1;
                    cpl_valid_d    = 1'b1;
                    rem_d          = 11'd0;
                    state_d        = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= S_IDLE;
            req_compl_q    <= 1'b0;
            req_compl_wd_q <= 1'b0;
            req_tc_q       <= 3'd0;
            req_td_q       <= 1'b0;
            req_ep_q       <= 1'b0;
            req_attr_q     <= 2'd0;
            req_len_q      <= 10'd0;
            req_rid_q      <= 16'd0;
            req_tag_q      <= 8'd0;
            req_be_q       <= 8'd0;
            req_addr_q     <= 32'd0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= 32'd0;
            wr_be_q        <= 4'd0;
            wr_data_q      <= 32'd0;
            cpl_data_q     <= 128'd0;
            cpl_dw_valid_q <= 4'd0;
            cpl_tag_q      <= 8'd0;
            cpl_last_q     <= 1'b0;
            cpl_valid_q    <= 1'b0;
            tag_hold_q     <= 8'd0;
            scratch_q      <= 32'd0;
            rem_q          <= 11'd0;
        end else begin
            state_q        <= state_d;
            req_compl_q    <= req_compl_d;
            req_compl_wd_q <= req_compl_wd_d;
            req_tc_q       <= req_tc_d;
            req_td_q       <= req_td_d;
            req_ep_q       <= req_ep_d;
            req_attr_q     <= req_attr_d;
            req_len_q      <= req_len_d;
            req_rid_q      <= req_rid_d;
            req_tag_q      <= req_tag_d;
            req_be_q       <= req_be_d;
            req_addr_q     <= req_addr_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_be_q        <= wr_be_d;
            wr_data_q      <= wr_data_d;
            cpl_data_q     <= cpl_data_d;
            cpl_dw_valid_q <= cpl_dw_valid_d;
            cpl_tag_q      <= cpl_tag_d;
            cpl_last_q     <= cpl_last_d;
            cpl_valid_q    <= cpl_valid_d;
            tag_hold_q     <= tag_hold_d;
            scratch_q      <= scratch_d;
            rem_q          <= rem_d;
        end
    end

    assign req_compl    = req_compl_q;
    assign req_compl_wd = req_compl_wd_q;
    assign req_tc       = req_tc_q;
    assign req_td       = req_td_q;
    assign req_ep       = req_ep_q;
    assign req_attr     = req_attr_q;
    assign req_len      = req_len_q;
    assign req_rid      = req_rid_q;
    assign req_tag      = req_tag_q;
    assign req_be       = req_be_q;
    assign req_addr     = req_addr_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_be        = wr_be_q;
    assign wr_data      = wr_data_q;
    assign cpl_data     = cpl_data_q;
    assign cpl_dw_valid = cpl_dw_valid_q;
    assign cpl_tag      = cpl_tag_q;
    assign cpl_last     = cpl_last_q;
    assign cpl_valid    = cpl_valid_q;

endmodule

// File: tb/tb_xilinx_pcie_rx_engine.sv
// -----------------------------------------------------------------------------
// tb_xilinx_pcie_rx_engine
//
// Builds TLPs as lists of 128-bit beats, predicts the resulting req/wr/cpl
// transactions directly from the TLP contents (payload chopped into groups of
// four DWs), and compares every DUT output transaction against those
// predictions from one per-cycle compare routine. Directed cases pin known
// literal values; a randomized phase mixes TLP types, lengths, gaps and
// cpl_ready backpressure.
// -----------------------------------------------------------------------------
module tb_xilinx_pcie_rx_engine;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic [127:0] m_axis_rx_tdata = '0;
    logic [15:0]  m_axis_rx_tkeep = 16'hFFFF;
    logic         m_axis_rx_tlast = 1'b0;
    logic         m_axis_rx_tvalid = 1'b0;
    logic         m_axis_rx_tready;
    logic         req_compl, req_compl_wd, req_td, req_ep;
    logic [2:0]   req_tc;
    logic [1:0]   req_attr;
    logic [9:0]   req_len;
    logic [15:0]  req_rid;
    logic [7:0]   req_tag, req_be;
    logic [31:0]  req_addr;
    logic         compl_done = 1'b0;
    logic         wr_en;
    logic [31:0]  wr_addr, wr_data;
    logic [3:0]   wr_be;
    logic [127:0] cpl_data;
    logic [3:0]   cpl_dw_valid;
    logic [7:0]   cpl_tag;
    logic         cpl_last, cpl_valid;
    logic         cpl_ready = 1'b1;

    xilinx_pcie_rx_engine dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .m_axis_rx_tdata(m_axis_rx_tdata), .m_axis_rx_tkeep(m_axis_rx_tkeep),
        .m_axis_rx_tlast(m_axis_rx_tlast), .m_axis_rx_tvalid(m_axis_rx_tvalid),
        .m_axis_rx_tready(m_axis_rx_tready),
        .req_compl(req_compl), .req_compl_wd(req_compl_wd), .req_tc(req_tc),
        .req_td(req_td), .req_ep(req_ep), .req_attr(req_attr), .req_len(req_len),
        .req_rid(req_rid), .req_tag(req_tag), .req_be(req_be), .req_addr(req_addr),
        .compl_done(compl_done),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .cpl_data(cpl_data), .cpl_dw_valid(cpl_dw_valid), .cpl_tag(cpl_tag),
        .cpl_last(cpl_last), .cpl_valid(cpl_valid), .cpl_ready(cpl_ready)
    );

    initial forever #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [2:0]  tc;
        logic        td;
        logic        ep;
        logic [1:0]  attr;
        logic [9:0]  len;
        logic [15:0] rid;
        logic [7:0]  tag;
        logic [7:0]  be;
        logic [31:0] addr;
    } req_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   cmp;   // lanes whose contents are defined
        logic [3:0]   mask;
        logic [7:0]   tag;
        logic         last;
    } cw_t;

    req_t req_q[$];
    wr_t  wr_q[$];
    cw_t  cpl_q[$];
    cw_t  got_q[$];
    logic [127:0] beat_q[$];

    int   checks = 0;
    int   fails = 0;
    int   wr_count = 0;
    req_t last_req;
    wr_t  last_wr;
    int   ready_mode = 0;      // 0: always ready, 1: toggle, 2: random
    bit   cur_is_cpl = 0;
    int   cur_beat = 0;

    task automatic chk(input bit ok, input string name,
                       input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // cpl_ready driver
    initial forever begin
        @(posedge i_clk);
        #1;
        case (ready_mode)
            0:       cpl_ready = 1'b1;
            1:       cpl_ready = ~cpl_ready;
            default: cpl_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Per-cycle compare against the predicted transactions.
    bit           prev_hold = 0;
    logic [127:0] h_data;
    logic [3:0]   h_mask;
    logic [7:0]   h_tag;
    logic         h_last;

    task automatic check_cycle();
        req_t r;
        wr_t  w;
        cw_t  e, a;
        bit   ok;
        if (!i_rst_n) begin
            prev_hold = 0;
            return;
        end
        if (prev_hold) begin
            chk(cpl_valid && cpl_data == h_data && cpl_dw_valid == h_mask &&
                cpl_tag == h_tag && cpl_last == h_last, "cpl_hold",
                {cpl_valid, cpl_data[31:0]}, {1'b1, h_data[31:0]});
        end
        if (cur_is_cpl && cur_beat > 0 && m_axis_rx_tvalid && cpl_valid && !cpl_ready)
            chk(m_axis_rx_tready == 1'b0, "stream_tready_gate", m_axis_rx_tready, 0);
        if (req_compl) begin
            r = {req_tc, req_td, req_ep, req_attr, req_len, req_rid, req_tag, req_be, req_addr};
            last_req = r;
            if (req_q.size() == 0) chk(0, "unexpected_req_compl", r, 0);
            else begin
                req_t x = req_q.pop_front();
                chk(r == x && req_compl_wd == 1'b1, "req_fields", {req_compl_wd, r}, {1'b1, x});
            end
        end
        if (wr_en) begin
            w = {wr_addr, wr_be, wr_data};
            last_wr = w;
            wr_count++;
            if (wr_q.size() == 0) chk(0, "unexpected_wr_en", w, 0);
            else begin
                wr_t x = wr_q.pop_front();
                chk(w == x, "wr_fields", w, x);
            end
        end
        if (cpl_valid && cpl_ready) begin
            a = {cpl_data, 4'hF, cpl_dw_valid, cpl_tag, cpl_last};
            got_q.push_back(a);
            if (cpl_q.size() == 0) chk(0, "unexpected_cpl_word", cpl_data, 0);
            else begin
                e = cpl_q.pop_front();
                ok = 1;
                for (int j = 0; j < 4; j++)
                    if (e.cmp[j] && cpl_data[32*j +: 32] != e.data[32*j +: 32]) ok = 0;
                chk(ok, "cpl_data", cpl_data, e.data);
                chk(cpl_dw_valid == e.mask && cpl_tag == e.tag && cpl_last == e.last,
                    "cpl_ctrl", {cpl_dw_valid, cpl_tag, cpl_last}, {e.mask, e.tag, e.last});
            end
        end
        prev_hold = cpl_valid && !cpl_ready;
        h_data = cpl_data; h_mask = cpl_dw_valid; h_tag = cpl_tag; h_last = cpl_last;
    endtask

    initial forever begin
        @(negedge i_clk);
        check_cycle();
    end

    function automatic logic [31:0] mk_dw0(input logic [6:0] ft, input logic [9:0] len,
                                           input logic [2:0] tc, input logic td,
                                           input logic ep, input logic [1:0] attr);
        return {1'b0, ft, 1'b0, tc, 4'b0, td, ep, attr, 2'b0, len};
    endfunction

    function automatic logic [127:0] junk128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Sends beat_q as one TLP; no_last suppresses tlast on the final beat.
    task automatic send_beats(input bit gaps, input bit no_last);
        int n = beat_q.size();
        for (int b = 0; b < n; b++) begin
            int t = 0;
            bit acc = 0;
            if (gaps && $urandom_range(0, 3) == 0) begin
                m_axis_rx_tvalid = 1'b0;
                @(posedge i_clk);
                #1;
            end
            cur_beat = b;
            m_axis_rx_tdata = beat_q[b];
            m_axis_rx_tlast = (b == n - 1) && !no_last;
            m_axis_rx_tvalid = 1'b1;
            while (!acc) begin
                @(negedge i_clk);
                acc = m_axis_rx_tready;
                @(posedge i_clk);
                #1;
                t++;
                if (!acc && t > 3000) begin
                    chk(0, "beat_accept_timeout", t, 3000);
                    break;
                end
            end
        end
        m_axis_rx_tvalid = 1'b0;
        m_axis_rx_tlast = 1'b0;
        m_axis_rx_tdata = junk128();
        cur_is_cpl = 0;
        beat_q.delete();
    endtask

    task automatic do_mrd(input logic [7:0] tag, input logic [31:0] addr,
                          input logic [7:0] be, input logic [9:0] len, input bit gaps);
        req_t e;
        int   w;
        e.tc = 3'($urandom); e.td = 1'($urandom); e.ep = 1'($urandom);
        e.attr = 2'($urandom); e.len = len; e.rid = 16'($urandom);
        e.tag = tag; e.be = be; e.addr = {addr[31:2], 2'b00};
        req_q.push_back(e);
        beat_q.push_back({$urandom, addr, e.rid, tag, be,
                          mk_dw0(7'h00, len, e.tc, e.td, e.ep, e.attr)});
        send_beats(gaps, 0);
        w = $urandom_range(1, 5);
        repeat (w) begin
            @(negedge i_clk);
            chk(m_axis_rx_tready == 1'b0, "rdwait_tready", m_axis_rx_tready, 0);
            chk(req_addr == e.addr && req_tag == e.tag && req_be == e.be,
                "rdwait_req_stable", {req_addr, req_tag, req_be}, {e.addr, e.tag, e.be});
            @(posedge i_clk);
            #1;
        end
        compl_done = 1'b1;
        @(posedge i_clk);
        #1;
        compl_done = 1'b0;
        @(negedge i_clk);
        chk(m_axis_rx_tready == 1'b1, "rdwait_release", m_axis_rx_tready, 1);
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_mwr(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input int len, input bit gaps);
        wr_t e;
        int  extra = (len - 1 + 3) / 4;
        e.addr = {addr[31:2], 2'b00}; e.be = be; e.data = data;
        wr_q.push_back(e);
        beat_q.push_back({data, addr, 16'($urandom), 8'($urandom), 4'hF, be,
                          mk_dw0(7'h40, 10'(len), 3'd0, 1'b0, 1'b0, 2'd0)});
        for (int i = 0; i < extra; i++) beat_q.push_back(junk128());
        send_beats(gaps, 0);
    endtask

    task automatic do_other(input logic [6:0] ft, input int beats, input bit gaps);
        logic [127:0] b0 = junk128();
        b0[31:0] = mk_dw0(ft, 10'(beats * 4), 3'd0, 1'b0, 1'b0, 2'd0);
        beat_q.push_back(b0);
        for (int i = 1; i < beats; i++) beat_q.push_back(junk128());
        send_beats(gaps, 0);
    endtask

    // Builds a CplD of len DWs (1..1024) and predicts its output words.
    // With partial set, only the header and first payload beat are sent.
    task automatic do_cpld(input int len, input logic [7:0] tag, input bit seq,
                           input bit gaps, input bit partial);
        logic [31:0]  pl[$];
        logic [127:0] b;
        int           idx, nw, cnt;
        cw_t          e;
        for (int i = 0; i < len; i++) pl.push_back(seq ? 32'hA000_0000 + i : $urandom);
        beat_q.push_back({pl[0], 16'($urandom), tag, 8'($urandom), $urandom,
                          mk_dw0(7'h4A, 10'(len), 3'd0, 1'b0, 1'b0, 2'd0)});
        idx = 1;
        while (idx < len) begin
            b = junk128();
            for (int j = 0; j < 4; j++)
                if (idx < len) begin
                    b[32*j +: 32] = pl[idx];
                    idx++;
                end
            beat_q.push_back(b);
        end
        nw = (len + 3) / 4;
        for (int k = 0; k < nw; k++) begin
            cnt = (len - 4 * k >= 4) ? 4 : len - 4 * k;
            e.data = '0;
            for (int j = 0; j < cnt; j++) e.data[32*j +: 32] = pl[4 * k + j];
            e.mask = 4'((1 << cnt) - 1);
            e.last = (k == nw - 1);
            e.tag = tag;
            e.cmp = (e.last && (len % 4 == 1)) ? 4'hF : e.mask;
            if (!partial || k == 0) cpl_q.push_back(e);
        end
        if (partial) while (beat_q.size() > 2) void'(beat_q.pop_back());
        cur_is_cpl = 1;
        send_beats(gaps, partial);
    endtask

    task automatic drain();
        int t = 0;
        while ((cpl_q.size() != 0 || req_q.size() != 0 || wr_q.size() != 0) && t < 5000) begin
            @(posedge i_clk);
            #1;
            t++;
        end
        repeat (3) @(posedge i_clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        chk({req_compl, req_compl_wd, req_tc, req_td, req_ep, req_attr, req_len,
             req_rid, req_tag, req_be, req_addr} == '0, {name, "_req"}, req_addr, 0);
        chk({wr_en, wr_addr, wr_be, wr_data} == '0, {name, "_wr"}, {wr_en, wr_addr, wr_data}, 0);
        chk(cpl_data == '0, {name, "_cpl_data"}, cpl_data, 0);
        chk({cpl_dw_valid, cpl_tag, cpl_last, cpl_valid} == '0, {name, "_cpl_ctrl"},
            {cpl_dw_valid, cpl_tag, cpl_last, cpl_valid}, 0);
        chk(m_axis_rx_tready == 1'b1, {name, "_tready"}, m_axis_rx_tready, 1);
    endtask

    initial begin
        int wr_before, r;
        logic [6:0] other_ft[4];
        other_ft[0] = 7'h42; other_ft[1] = 7'h20; other_ft[2] = 7'h0A; other_ft[3] = 7'h30;

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        check_all_zero("reset");
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // MRd directed
        do_mrd(8'h12, 32'h0000_1004, 8'h0F, 10'd1, 0);
        chk(last_req.addr == 32'h0000_1004, "mrd_lit_addr", last_req.addr, 32'h1004);
        chk(last_req.tag == 8'h12 && last_req.be == 8'h0F, "mrd_lit_tag_be",
            {last_req.tag, last_req.be}, 16'h120F);

        // MWr directed, len 1 and len 4
        wr_before = wr_count;
        do_mwr(32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 1, 0);
        drain();
        chk(last_wr.data == 32'hDEAD_BEEF && last_wr.addr == 32'h20, "mwr_lit",
            {last_wr.addr, last_wr.data}, 64'h00000020_DEADBEEF);
        do_mwr(32'h0000_0044, 32'h1234_5678, 4'h3, 4, 0);
        drain();
        chk(wr_count - wr_before == 2, "mwr_pulse_count", wr_count - wr_before, 2);

        // CplD len 8
        got_q.delete();
        do_cpld(8, 8'h05, 1, 0, 0);
        drain();
        chk(got_q.size() == 2, "cpl8_words", got_q.size(), 2);
        chk(got_q[0].data == 128'hA0000003_A0000002_A0000001_A0000000, "cpl8_w0",
            got_q[0].data, 128'hA0000003_A0000002_A0000001_A0000000);
        chk(got_q[1].data == 128'hA0000007_A0000006_A0000005_A0000004, "cpl8_w1",
            got_q[1].data, 128'hA0000007_A0000006_A0000005_A0000004);
        chk(got_q[0].mask == 4'hF && got_q[1].mask == 4'hF && !got_q[0].last &&
            got_q[1].last && got_q[1].tag == 8'h05, "cpl8_ctrl",
            {got_q[0].mask, got_q[1].mask, got_q[0].last, got_q[1].last, got_q[1].tag},
            {4'hF, 4'hF, 1'b0, 1'b1, 8'h05});

        // CplD len 5 and len 1 (flush words)
        got_q.delete();
        do_cpld(5, 8'h33, 1, 0, 0);
        drain();
        chk(got_q[1].data == 128'h00000000_00000000_00000000_A0000004 &&
            got_q[1].mask == 4'h1 && got_q[1].last, "cpl5_flush",
            {got_q[1].mask, got_q[1].data[31:0]}, {4'h1, 32'hA0000004});
        got_q.delete();
        do_cpld(1, 8'h77, 1, 0, 0);
        drain();
        chk(got_q.size() == 1 && got_q[0].data == 128'h00000000_00000000_00000000_A0000000 &&
            got_q[0].mask == 4'h1 && got_q[0].last, "cpl1_flush",
            got_q[0].data, 128'hA0000000);

        // Backpressure: len 16 with cpl_ready toggling
        ready_mode = 1;
        do_cpld(16, 8'hC3, 0, 0, 0);
        drain();
        ready_mode = 0;

        // Length field 0 means 1024 DWs
        do_cpld(1024, 8'h9A, 0, 0, 0);
        drain();

        // Unsupported IO write, 3 beats: nothing may pulse
        do_other(7'h42, 3, 0);
        drain();

        // Randomized mix
        ready_mode = 2;
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      do_mrd(8'($urandom), $urandom, 8'($urandom), 10'($urandom), 1);
            else if (r < 4) do_mwr($urandom, $urandom, 4'($urandom), $urandom_range(1, 9), 1);
            else if (r < 9) do_cpld($urandom_range(1, 24), 8'($urandom), 0, 1, 0);
            else            do_other(other_ft[$urandom_range(0, 3)], $urandom_range(1, 3), 1);
        end
        drain();
        ready_mode = 0;

        // Reset in the middle of a CplD
        do_cpld(12, 8'h44, 0, 0, 1);
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        cpl_q.delete(); req_q.delete(); wr_q.delete();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        do_mwr(32'h0000_0100, 32'hCAFE_F00D, 4'h1, 1, 0);
        drain();

        chk(cpl_q.size() == 0, "cpl_queue_empty", cpl_q.size(), 0);
        chk(req_q.size() == 0 && wr_q.size() == 0, "req_wr_queue_empty",
            {req_q.size(), wr_q.size()}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
